// File: rtl/peripheral_bb_pkg.sv
// Shared types and helpers for bb-bus slaves: FSM state encoding,
// index-width calculation and the byte-lane write merge.
package peripheral_bb_pkg;

    typedef enum logic [1:0] {
        BB_IDLE,
        BB_WAIT,
        BB_DONE
    } bb_state_t;

    // Widest bus any bb slave supports; bb_merge works at this width.
    localparam int BB_MAX_W = 64;

    // Number of address bits needed to select one of n registers.
    function automatic int bb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Byte b of the result comes from din when wen[b] is set, else from old.
    function automatic logic [BB_MAX_W-1:0] bb_merge(input logic [BB_MAX_W-1:0] old,
                                                     input logic [BB_MAX_W-1:0] din,
                                                     input logic [BB_MAX_W/8-1:0] wen);
        logic [BB_MAX_W-1:0] r;
        r = old;
        for (int b = 0; b < BB_MAX_W / 8; b++) begin
            if (wen[b]) r[b*8 +: 8] = din[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/peripheral_bb_wait_counter.sv
// Four-bit loadable down-counter used to insert wait states in bb slaves.
// done is high while the count sits at 1, i.e. the last wait cycle.
module peripheral_bb_wait_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    input  logic       clr,
    output logic       done
);

    logic [3:0] count;

    // Clear and load take priority over decrement; the count never wraps below zero.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

    assign done = (count == 4'd1);

endmodule

// File: rtl/peripheral_bb_regfile.sv
// Parametrised bb-bus register-file slave with wait states, byte-lane
// writes, a one-cycle ready strobe, per-register write strobes and a
// flat export of all registers for downstream logic.
module peripheral_bb_regfile
    import peripheral_bb_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    NUM_REGS    = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(16'h0100),
    parameter int                    WAIT_STATES = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                           mclk,
    input  logic                           rst,
    input  logic                           cen,
    input  logic [DATA_WIDTH/8-1:0]        wen,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic [DATA_WIDTH-1:0]          din,
    output logic [DATA_WIDTH-1:0]          dout,
    output logic                           ready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
    output logic [NUM_REGS-1:0]            wr_stb
);

    localparam int         IDX_W   = bb_idx_w(NUM_REGS);
    localparam int         NB      = DATA_WIDTH / 8;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

    bb_state_t             state;
    bb_state_t             state_nx;
    logic                  hit;
    logic                  accept;
    logic                  cnt_load;
    logic                  cnt_en;
    logic                  cnt_clr;
    logic                  cnt_done;
    logic                  complete;
    logic                  is_write;
    logic [IDX_W-1:0]      idx_q;
    logic [NB-1:0]         wen_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic [DATA_WIDTH-1:0] merged;
    logic [NUM_REGS-1:0]   stb_sel;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    assign hit = cen && (addr[ADDR_WIDTH-1:IDX_W] == BASE_ADDR[ADDR_WIDTH-1:IDX_W]);

    peripheral_bb_wait_counter u_wait (
        .clk      (mclk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (WAIT_LD),
        .en       (cnt_en),
        .clr      (cnt_clr),
        .done     (cnt_done)
    );

    // State register.
    always_ff @(posedge mclk) begin
        if (rst) state <= BB_IDLE;
        else     state <= state_nx;
    end

    // Next-state and per-cycle control; dropping cen mid-wait abandons the access.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_clr  = 1'b0;
        complete = 1'b0;
        case (state)
            BB_IDLE: begin
                if (hit) begin
                    accept   = 1'b1;
                    cnt_load = 1'b1;
                    state_nx = (WAIT_STATES == 0) ? BB_DONE : BB_WAIT;
                end
            end
            BB_WAIT: begin
                if (!cen) begin
                    cnt_clr  = 1'b1;
                    state_nx = BB_IDLE;
                end else if (cnt_done) begin
                    state_nx = BB_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            BB_DONE: begin
                complete = 1'b1;
                state_nx = BB_IDLE;
            end
            default: state_nx = BB_IDLE;
        endcase
    end

    // Capture the request at acceptance so later bus changes cannot affect it.
    always_ff @(posedge mclk) begin
        if (accept) begin
            idx_q <= addr[IDX_W-1:0];
            wen_q <= wen;
            din_q <= din;
        end
    end

    assign is_write = |wen_q;
    assign merged   = DATA_WIDTH'(bb_merge(BB_MAX_W'(regs[idx_q]), BB_MAX_W'(din_q),
                                           (BB_MAX_W/8)'(wen_q)));

    // One-hot select of the captured register for the write strobe.
    always_comb begin
        stb_sel        = '0;
        stb_sel[idx_q] = 1'b1;
    end

    // Register array; writes land on the completion edge.
    always_ff @(posedge mclk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else if (complete && is_write) begin
            regs[idx_q] <= merged;
        end
    end

    // Registered bus outputs; dout is zero except on a read completion so it can be OR-ed.
    always_ff @(posedge mclk) begin
        if (rst) begin
            dout   <= '0;
            ready  <= 1'b0;
            wr_stb <= '0;
        end else begin
            ready  <= complete;
            dout   <= (complete && !is_write) ? regs[idx_q] : '0;
            wr_stb <= (complete && is_write) ? stb_sel : '0;
        end
    end

    // Flatten the register array for downstream logic.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) reg_o[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end

endmodule

// File: tb/tb_peripheral_bb_regfile.sv
// Bench for peripheral_bb_regfile: four 16-bit instances with different wait
// states plus one 32-bit, four-register instance at base 0x0200.
module tb_peripheral_bb_regfile;

    logic mclk = 1'b0;
    always #5 mclk = ~mclk;

    int n_cmp = 0;
    int n_mis = 0;

    // 16-bit instances: index 0..3 have WAIT_STATES 1, 0, 15, 3.
    logic [3:0]        rst16;
    logic [3:0]        cen16;
    logic [3:0][1:0]   wen16;
    logic [3:0][15:0]  addr16;
    logic [3:0][15:0]  din16;
    wire  [3:0][15:0]  dout16;
    wire  [3:0]        ready16;
    wire  [3:0][127:0] rego16;
    wire  [3:0][7:0]   stb16;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g16
            peripheral_bb_regfile #(
                .DATA_WIDTH (16),
                .ADDR_WIDTH (16),
                .NUM_REGS   (8),
                .BASE_ADDR  (16'h0100),
                .WAIT_STATES(g == 0 ? 1 : g == 1 ? 0 : g == 2 ? 15 : 3),
                .RESET_VAL  (16'h0000)
            ) u_dut (
                .mclk  (mclk),
                .rst   (rst16[g]),
                .cen   (cen16[g]),
                .wen   (wen16[g]),
                .addr  (addr16[g]),
                .din   (din16[g]),
                .dout  (dout16[g]),
                .ready (ready16[g]),
                .reg_o (rego16[g]),
                .wr_stb(stb16[g])
            );
        end
    endgenerate

    logic         rst32;
    logic         cen32;
    logic [3:0]   wen32;
    logic [15:0]  addr32;
    logic [31:0]  din32;
    wire  [31:0]  dout32;
    wire          ready32;
    wire  [127:0] rego32;
    wire  [3:0]   stb32;

    peripheral_bb_regfile #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (16),
        .NUM_REGS   (4),
        .BASE_ADDR  (16'h0200),
        .WAIT_STATES(1),
        .RESET_VAL  (32'h0)
    ) u_dut32 (
        .mclk  (mclk),
        .rst   (rst32),
        .cen   (cen32),
        .wen   (wen32),
        .addr  (addr32),
        .din   (din32),
        .dout  (dout32),
        .ready (ready32),
        .reg_o (rego32),
        .wr_stb(stb32)
    );

    // Reference model: register contents per instance.
    logic [15:0] m16 [4][8];
    logic [31:0] m32 [4];

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 0 : (k == 2) ? 15 : 3;
    endfunction

    function automatic logic [15:0] mrg16(input logic [15:0] old, input logic [15:0] d,
                                          input logic [1:0] w);
        logic [15:0] mask;
        mask = {{8{w[1]}}, {8{w[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    function automatic logic [127:0] exp16(input int k);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = m16[k][i];
        return r;
    endfunction

    function automatic logic [127:0] exp32();
        return {m32[3], m32[2], m32[1], m32[0]};
    endfunction

    // Drives one access on 16-bit instance k and records what the DUT did.
    // drop_at / rst_at: cycle (after accept) at which cen drops / rst pulses; -1 = never.
    task automatic xfer16(input int k, input logic [15:0] a, input logic [1:0] w,
                          input logic [15:0] d, input int drop_at, input int rst_at,
                          input int budget, output int rdy_cyc, output int rdy_cnt,
                          output logic [15:0] rd, output logic [7:0] stb, output int stray);
        rdy_cyc = -1; rdy_cnt = 0; rd = '0; stb = '0; stray = 0;
        @(negedge mclk);
        cen16[k] = 1'b1; addr16[k] = a; wen16[k] = w; din16[k] = d;
        for (int c = 0; c <= budget; c++) begin
            @(posedge mclk);
            @(negedge mclk);
            if (ready16[k]) begin
                if (rdy_cyc < 0) begin
                    rdy_cyc = c; rd = dout16[k]; stb = stb16[k];
                end
                rdy_cnt++;
                cen16[k] = 1'b0;
            end else if (dout16[k] != 16'h0 || stb16[k] != 8'h0) begin
                stray++;
            end
            if (c == 0 && a[15:3] == 13'h0020) begin
                addr16[k] = 16'($urandom); din16[k] = 16'($urandom); wen16[k] = 2'($urandom);
            end
            if (c == drop_at) cen16[k] = 1'b0;
            if (c == rst_at) rst16[k] = 1'b1;
            else if (c == rst_at + 1) rst16[k] = 1'b0;
        end
        cen16[k] = 1'b0;
        rst16[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst16 = '1; rst32 = 1'b1;
        repeat (2) @(posedge mclk);
        @(negedge mclk);
        rst16 = '0; rst32 = 1'b0;
        for (int k = 0; k < 4; k++) for (int i = 0; i < 8; i++) m16[k][i] = 16'h0;
        for (int i = 0; i < 4; i++) m32[i] = 32'h0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (rego16[k] !== exp16(k)) begin n_mis++; $display("FAIL reset_rego[%0d]: got %h want %h", k, rego16[k], exp16(k)); end
            n_cmp++; if (dout16[k] !== 16'h0) begin n_mis++; $display("FAIL reset_dout[%0d]: got %h want 0", k, dout16[k]); end
            n_cmp++; if (ready16[k] !== 1'b0) begin n_mis++; $display("FAIL reset_ready[%0d]: got %b want 0", k, ready16[k]); end
            n_cmp++; if (stb16[k] !== 8'h0) begin n_mis++; $display("FAIL reset_stb[%0d]: got %h want 0", k, stb16[k]); end
        end
        n_cmp++; if (rego32 !== 128'h0) begin n_mis++; $display("FAIL reset_rego32: got %h want 0", rego32); end
        n_cmp++; if (dout32 !== 32'h0 || ready32 !== 1'b0 || stb32 !== 4'h0) begin
            n_mis++; $display("FAIL reset_out32: dout %h ready %b stb %h want all 0", dout32, ready32, stb32);
        end
    endtask

    task automatic test_full_write();
        int rc, rn, st; logic [15:0] rd; logic [7:0] sb;
        xfer16(0, 16'h0103, 2'b11, 16'hBEEF, -1, -1, 6, rc, rn, rd, sb, st);
        m16[0][3] = 16'hBEEF;
        n_cmp++; if (rc !== 2) begin n_mis++; $display("FAIL wr_ready_cycle: got %0d want 2", rc); end
        n_cmp++; if (rn !== 1) begin n_mis++; $display("FAIL wr_ready_count: got %0d want 1", rn); end
        n_cmp++; if (sb !== 8'h08) begin n_mis++; $display("FAIL wr_stb: got %h want 08", sb); end
        n_cmp++; if (rd !== 16'h0 || st !== 0) begin n_mis++; $display("FAIL wr_dout: dout %h stray %0d want 0/0", rd, st); end
        n_cmp++; if (rego16[0] !== exp16(0)) begin n_mis++; $display("FAIL wr_rego: got %h want %h", rego16[0], exp16(0)); end
        xfer16(0, 16'h0103, 2'b00, 16'h5A5A, -1, -1, 6, rc, rn, rd, sb, st);
        n_cmp++; if (rc !== 2) begin n_mis++; $display("FAIL rd_ready_cycle: got %0d want 2", rc); end
        n_cmp++; if (rd !== 16'hBEEF) begin n_mis++; $display("FAIL rd_dout: got %h want BEEF", rd); end
        n_cmp++; if (sb !== 8'h0 || st !== 0 || rn !== 1) begin
            n_mis++; $display("FAIL rd_side: stb %h stray %0d readies %0d want 0/0/1", sb, st, rn);
        end
    endtask

    task automatic test_byte_lane();
        int rc, rn, st; logic [15:0] rd; logic [7:0] sb;
        xfer16(0, 16'h0102, 2'b11, 16'h1234, -1, -1, 5, rc, rn, rd, sb, st);
        xfer16(0, 16'h0102, 2'b10, 16'hAB00, -1, -1, 5, rc, rn, rd, sb, st);
        n_cmp++; if (rego16[0][47:32] !== 16'hAB34) begin n_mis++; $display("FAIL lane_hi: got %h want AB34", rego16[0][47:32]); end
        n_cmp++; if (sb !== 8'h04) begin n_mis++; $display("FAIL lane_hi_stb: got %h want 04", sb); end
        xfer16(0, 16'h0102, 2'b01, 16'h00CD, -1, -1, 5, rc, rn, rd, sb, st);
        n_cmp++; if (rego16[0][47:32] !== 16'hABCD) begin n_mis++; $display("FAIL lane_lo: got %h want ABCD", rego16[0][47:32]); end
        n_cmp++; if (sb !== 8'h04) begin n_mis++; $display("FAIL lane_lo_stb: got %h want 04", sb); end
        m16[0][2] = 16'hABCD;
    endtask

    task automatic test_wait_states();
        int rc, rn, st; logic [15:0] rd, d; logic [7:0] sb;
        d = 16'($urandom);
        xfer16(1, 16'h0106, 2'b11, d, -1, -1, 4, rc, rn, rd, sb, st);
        m16[1][6] = d;
        n_cmp++; if (rc !== 1) begin n_mis++; $display("FAIL ws0_cycle: got %0d want 1", rc); end
        n_cmp++; if (rego16[1] !== exp16(1)) begin n_mis++; $display("FAIL ws0_rego: got %h want %h", rego16[1], exp16(1)); end
        xfer16(2, 16'h0101, 2'b11, d, -1, -1, 20, rc, rn, rd, sb, st);
        m16[2][1] = d;
        n_cmp++; if (rc !== 16) begin n_mis++; $display("FAIL ws15_cycle: got %0d want 16", rc); end
        n_cmp++; if (rego16[2] !== exp16(2)) begin n_mis++; $display("FAIL ws15_rego: got %h want %h", rego16[2], exp16(2)); end
        xfer16(0, 16'h0108, 2'b11, 16'hFFFF, -1, -1, 20, rc, rn, rd, sb, st);
        n_cmp++; if (rn !== 0 || st !== 0) begin n_mis++; $display("FAIL miss: readies %0d stray %0d want 0/0", rn, st); end
        n_cmp++; if (rego16[0] !== exp16(0)) begin n_mis++; $display("FAIL miss_rego: got %h want %h", rego16[0], exp16(0)); end
    endtask

    task automatic test_abort();
        int rc, rn, st; logic [15:0] rd; logic [7:0] sb;
        xfer16(3, 16'h0105, 2'b11, 16'h1111, -1, -1, 6, rc, rn, rd, sb, st);
        m16[3][5] = 16'h1111;
        n_cmp++; if (rc !== 4) begin n_mis++; $display("FAIL ws3_cycle: got %0d want 4", rc); end
        xfer16(3, 16'h0105, 2'b11, 16'h2222, 2, -1, 8, rc, rn, rd, sb, st);
        n_cmp++; if (rn !== 0 || st !== 0) begin n_mis++; $display("FAIL abort_cen: readies %0d stray %0d want 0/0", rn, st); end
        n_cmp++; if (rego16[3] !== exp16(3)) begin n_mis++; $display("FAIL abort_cen_rego: got %h want %h", rego16[3], exp16(3)); end
        xfer16(3, 16'h0105, 2'b11, 16'h3333, 3, 2, 8, rc, rn, rd, sb, st);
        for (int i = 0; i < 8; i++) m16[3][i] = 16'h0;
        n_cmp++; if (rn !== 0 || st !== 0) begin n_mis++; $display("FAIL abort_rst: readies %0d stray %0d want 0/0", rn, st); end
        n_cmp++; if (rego16[3] !== exp16(3)) begin n_mis++; $display("FAIL abort_rst_rego: got %h want %h", rego16[3], exp16(3)); end
        xfer16(3, 16'h0105, 2'b00, 16'h0, -1, -1, 6, rc, rn, rd, sb, st);
        n_cmp++; if (rc !== 4 || rd !== 16'h0) begin n_mis++; $display("FAIL post_rst_read: cycle %0d dout %h want 4/0000", rc, rd); end
    endtask

    task automatic test_back_to_back();
        int rdy_c [2]; logic [3:0] rdy_s [2]; int nr; logic [31:0] d;
        nr = 0; rdy_c[0] = -1; rdy_c[1] = -1; rdy_s[0] = '0; rdy_s[1] = '0;
        @(negedge mclk);
        cen32 = 1'b1; addr32 = 16'h0200; wen32 = 4'hF; din32 = 32'hDEADBEEF;
        for (int c = 0; c <= 9; c++) begin
            @(posedge mclk);
            @(negedge mclk);
            if (ready32) begin
                if (nr < 2) begin rdy_c[nr] = c; rdy_s[nr] = stb32; end
                nr++;
                if (nr == 2) cen32 = 1'b0;
            end
        end
        cen32 = 1'b0;
        m32[0] = 32'hDEADBEEF;
        n_cmp++; if (nr !== 2) begin n_mis++; $display("FAIL b2b_count: got %0d want 2", nr); end
        n_cmp++; if (rdy_c[0] !== 2 || rdy_c[1] !== 5) begin n_mis++; $display("FAIL b2b_cycles: got %0d,%0d want 2,5", rdy_c[0], rdy_c[1]); end
        n_cmp++; if (rdy_s[0] !== 4'h1 || rdy_s[1] !== 4'h1) begin n_mis++; $display("FAIL b2b_stb: got %h,%h want 1,1", rdy_s[0], rdy_s[1]); end
        n_cmp++; if (rego32 !== exp32()) begin n_mis++; $display("FAIL b2b_rego: got %h want %h", rego32, exp32()); end
        d = $urandom; nr = 0; rdy_c[0] = -1; rdy_s[0] = '0;
        @(negedge mclk);
        cen32 = 1'b1; addr32 = 16'h0200; wen32 = 4'hF; din32 = d;
        for (int c = 0; c <= 5; c++) begin
            @(posedge mclk);
            @(negedge mclk);
            if (ready32) begin
                if (nr == 0) begin rdy_c[0] = c; rdy_s[0] = stb32; end
                nr++;
                cen32 = 1'b0;
            end
            if (c == 0) begin addr32 = 16'h0203; din32 = 32'h0; wen32 = 4'h3; end
        end
        cen32 = 1'b0;
        m32[0] = d;
        n_cmp++; if (rdy_c[0] !== 2 || nr !== 1) begin n_mis++; $display("FAIL capt_ready: cycle %0d count %0d want 2/1", rdy_c[0], nr); end
        n_cmp++; if (rdy_s[0] !== 4'h1) begin n_mis++; $display("FAIL capt_stb: got %h want 1", rdy_s[0]); end
        n_cmp++; if (rego32 !== exp32()) begin n_mis++; $display("FAIL capt_rego: got %h want %h", rego32, exp32()); end
    endtask

    task automatic test_random();
        int rc, rn, st, idx; logic [15:0] a, d, rd; logic [1:0] w; logic [7:0] sb; bit is_hit;
        for (int k = 0; k < 4; k++) begin
            for (int t = 0; t < 25; t++) begin
                is_hit = ($urandom_range(0, 3) != 0);
                idx = $urandom_range(0, 7);
                a = is_hit ? 16'(16'h0100 + idx) : 16'($urandom_range(16'h0108, 16'hFFFF));
                w = 2'($urandom); d = 16'($urandom);
                xfer16(k, a, w, d, -1, -1, is_hit ? ws_of(k) + 3 : 4, rc, rn, rd, sb, st);
                if (is_hit) begin
                    n_cmp++; if (rc !== ws_of(k) + 1 || rn !== 1) begin
                        n_mis++; $display("FAIL rnd_ready[%0d.%0d]: cycle %0d count %0d want %0d/1", k, t, rc, rn, ws_of(k) + 1);
                    end
                    n_cmp++; if (rd !== ((w == 2'b00) ? m16[k][idx] : 16'h0)) begin
                        n_mis++; $display("FAIL rnd_dout[%0d.%0d]: got %h want %h", k, t, rd, (w == 2'b00) ? m16[k][idx] : 16'h0);
                    end
                    n_cmp++; if (sb !== ((w != 2'b00) ? 8'(1 << idx) : 8'h0)) begin
                        n_mis++; $display("FAIL rnd_stb[%0d.%0d]: got %h want %h", k, t, sb, (w != 2'b00) ? 8'(1 << idx) : 8'h0);
                    end
                    m16[k][idx] = mrg16(m16[k][idx], d, w);
                end else begin
                    n_cmp++; if (rn !== 0) begin n_mis++; $display("FAIL rnd_miss[%0d.%0d]: readies %0d want 0", k, t, rn); end
                end
                n_cmp++; if (st !== 0) begin n_mis++; $display("FAIL rnd_stray[%0d.%0d]: got %0d want 0", k, t, st); end
                n_cmp++; if (rego16[k] !== exp16(k)) begin
                    n_mis++; $display("FAIL rnd_rego[%0d.%0d]: got %h want %h", k, t, rego16[k], exp16(k));
                end
            end
        end
    endtask

    initial begin
        rst16 = '1; cen16 = '0; wen16 = '0; addr16 = '0; din16 = '0;
        rst32 = 1'b1; cen32 = 1'b0; wen32 = '0; addr32 = '0; din32 = '0;
        test_reset();
        test_full_write();
        test_byte_lane();
        test_wait_states();
        test_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
